// File: rtl/if_stage_ctrl_if.sv
// ---------------------------------------------------------------------------
// if_stage_ctrl_if
// Bundles the hazard-unit requests, branch redirect, instruction-memory port
// and the IF/ID register outputs of the fetch stage controller.
//   master : hazard unit / memory / ID side (drives requests and mem data)
//   slave  : if_stage_ctrl (drives PC, IF/ID contents and status)
// ---------------------------------------------------------------------------
interface if_stage_ctrl_if;
    logic        pcHOLD;
    logic        IFIDRegHOLD;
    logic        IFflush;
    logic        branchTaken;
    logic [31:0] branchTarget;
    logic [31:0] instrMemData;
    logic [31:0] instrMemAddr;
    logic [31:0] IFIDinstr;
    logic [31:0] IFIDpcPlus4;
    logic        IFIDvalid;
    logic [5:0]  IFIDopcode;
    logic [4:0]  IFIDRegrs;
    logic [4:0]  IFIDRegrt;
    logic [1:0]  fsmState;
    logic [15:0] stallCount;
    logic [15:0] flushCount;
    logic        stallTimeout;

    modport master (
        output pcHOLD, IFIDRegHOLD, IFflush, branchTaken, branchTarget, instrMemData,
        input  instrMemAddr, IFIDinstr, IFIDpcPlus4, IFIDvalid, IFIDopcode,
               IFIDRegrs, IFIDRegrt, fsmState, stallCount, flushCount, stallTimeout
    );

    modport slave (
        input  pcHOLD, IFIDRegHOLD, IFflush, branchTaken, branchTarget, instrMemData,
        output instrMemAddr, IFIDinstr, IFIDpcPlus4, IFIDvalid, IFIDopcode,
               IFIDRegrs, IFIDRegrt, fsmState, stallCount, flushCount, stallTimeout
    );
endinterface

// File: rtl/if_stage_ctrl.sv
// ---------------------------------------------------------------------------
// if_stage_ctrl
// Instruction-fetch stage controller: owns the PC and the IF/ID pipeline
// register, applies hazard-unit hold/flush requests and taken-branch
// redirects, and keeps stall/flush statistics plus a sticky stall timeout.
// Ports:
//   clk   - single clock, rising edge
//   reset - synchronous active-high reset
//   bus   - if_stage_ctrl_if.slave (requests in; PC, IF/ID, status out)
// Parameters:
//   RESET_PC  - PC loaded on reset
//   MAX_STALL - consecutive pcHOLD cycles that raise stallTimeout (>= 1)
// ---------------------------------------------------------------------------
module if_stage_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MAX_STALL = 8
) (
    input  logic           clk,
    input  logic           reset,
    if_stage_ctrl_if.slave bus
);

    localparam int HW = $clog2(MAX_STALL + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STALL    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t          state_reg;
    logic [31:0]     pc_reg;
    logic [31:0]     ifid_instr_reg;
    logic [31:0]     ifid_pcplus4_reg;
    logic            ifid_valid_reg;
    logic [HW-1:0]   hold_run_reg;
    logic            stall_timeout_reg;

    logic [31:0]     pc_plus4;
    logic            branch_accepted;
    logic            load_bubble;

    assign pc_plus4 = pc_reg + 32'd4;

    // A branch presented during a PC hold is dropped; ID re-presents it.
    assign branch_accepted = bus.branchTaken & ~bus.pcHOLD;

    // A held IF/ID register never takes a bubble, even if flush is requested.
    assign load_bubble = ~bus.IFIDRegHOLD & (bus.IFflush | branch_accepted);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg            <= RESET_PC;
            ifid_instr_reg    <= 32'd0;
            ifid_pcplus4_reg  <= 32'd0;
            ifid_valid_reg    <= 1'b0;
            state_reg         <= ST_RUN;
            hold_run_reg      <= '0;
            stall_timeout_reg <= 1'b0;
        end else begin
            if (!bus.pcHOLD) begin
                if (branch_accepted)
                    pc_reg <= {bus.branchTarget[31:2], 2'b00};
                else
                    pc_reg <= pc_plus4;
            end

            if (!bus.IFIDRegHOLD) begin
                if (load_bubble) begin
                    ifid_instr_reg   <= 32'd0;
                    ifid_pcplus4_reg <= 32'd0;
                    ifid_valid_reg   <= 1'b0;
                end else begin
                    ifid_instr_reg   <= bus.instrMemData;
                    ifid_pcplus4_reg <= pc_plus4;
                    ifid_valid_reg   <= 1'b1;
                end
            end

            if (bus.pcHOLD)
                state_reg <= ST_STALL;
            else if (branch_accepted)
                state_reg <= ST_REDIRECT;
            else
                state_reg <= ST_RUN;

            // Run-length counter parks at MAX_STALL so it cannot wrap during
            // very long stalls; the flag fires on the edge that reaches it.
            if (bus.pcHOLD) begin
                if (hold_run_reg != HW'(MAX_STALL))
                    hold_run_reg <= hold_run_reg + 1'b1;
                if (hold_run_reg == HW'(MAX_STALL - 1))
                    stall_timeout_reg <= 1'b1;
            end else begin
                hold_run_reg <= '0;
            end
        end
    end

    // Two saturating statistics counters: [0] stall cycles, [1] bubbles.
    logic [1:0] cnt_inc;
    assign cnt_inc = {load_bubble, bus.pcHOLD};

    for (genvar gi = 0; gi < 2; gi++) begin : gen_cnt
        logic [15:0] cnt_reg;
        always_ff @(posedge clk) begin
            if (reset)
                cnt_reg <= 16'd0;
            else if (cnt_inc[gi] && (cnt_reg != 16'hFFFF))
                cnt_reg <= cnt_reg + 16'd1;
        end
    end

    assign bus.instrMemAddr = pc_reg;
    assign bus.IFIDinstr    = ifid_instr_reg;
    assign bus.IFIDpcPlus4  = ifid_pcplus4_reg;
    assign bus.IFIDvalid    = ifid_valid_reg;
    assign bus.IFIDopcode   = ifid_instr_reg[31:26];
    assign bus.IFIDRegrs    = ifid_instr_reg[25:21];
    assign bus.IFIDRegrt    = ifid_instr_reg[20:16];
    assign bus.fsmState     = state_reg;
    assign bus.stallCount   = gen_cnt[0].cnt_reg;
    assign bus.flushCount   = gen_cnt[1].cnt_reg;
    assign bus.stallTimeout = stall_timeout_reg;

endmodule

// File: tb/tb_if_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_if_stage_ctrl
// Directed table of fetch/stall/flush/branch vectors, hand sequences for the
// stall timeout, reset-mid-stall and PC wrap, then randomized traffic checked
// against a behavioural model of the fetch stage.
// ---------------------------------------------------------------------------
module tb_if_stage_ctrl;

    localparam int MAXS = 8;

    logic clk;
    logic rst1, rst2;
    int   tests = 0;
    int   fails = 0;

    if_stage_ctrl_if bus1 ();
    if_stage_ctrl_if bus2 ();

    if_stage_ctrl #(.RESET_PC(32'h0000_0000), .MAX_STALL(MAXS)) dut (
        .clk(clk), .reset(rst1), .bus(bus1)
    );

    if_stage_ctrl #(.RESET_PC(32'hFFFF_FFFC), .MAX_STALL(MAXS)) dut2 (
        .clk(clk), .reset(rst2), .bus(bus2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    assign bus1.instrMemData = mem_word(bus1.instrMemAddr);
    assign bus2.instrMemData = mem_word(bus2.instrMemAddr);

    // ---------------- behavioural reference model ----------------
    logic [31:0] m_pc, m_instr, m_p4;
    logic        m_v, m_to;
    int          m_st, m_sc, m_fc, m_run;

    task automatic model_step(input logic r, h, rh, f, b, input logic [31:0] t);
        bit take, bubble;
        if (r) begin
            m_pc = 32'h0; m_instr = 0; m_p4 = 0; m_v = 0;
            m_st = 0; m_sc = 0; m_fc = 0; m_run = 0; m_to = 0;
        end else begin
            take   = b && !h;
            bubble = !rh && (f || take);
            if (!rh) begin
                if (bubble) begin
                    m_instr = 0; m_p4 = 0; m_v = 0;
                end else begin
                    m_instr = mem_word(m_pc); m_p4 = m_pc + 4; m_v = 1;
                end
            end
            if (!h) m_pc = take ? (t & ~32'h3) : m_pc + 4;
            m_st = h ? 1 : (take ? 2 : 0);
            if (h && m_sc < 65535) m_sc++;
            if (bubble && m_fc < 65535) m_fc++;
            m_run = h ? m_run + 1 : 0;
            if (m_run >= MAXS) m_to = 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive1(input logic r, h, rh, f, b, input logic [31:0] t);
        rst1 = r;
        bus1.pcHOLD = h; bus1.IFIDRegHOLD = rh; bus1.IFflush = f;
        bus1.branchTaken = b; bus1.branchTarget = t;
        @(posedge clk);
        model_step(r, h, rh, f, b, t);
        #1;
        $display("[TB] rst=%0b hold=%0b rhold=%0b flush=%0b br=%0b tgt=%h -> pc=%h instr=%h p4=%h v=%0b st=%0d sc=%0d fc=%0d to=%0b",
                 r, h, rh, f, b, t, bus1.instrMemAddr, bus1.IFIDinstr, bus1.IFIDpcPlus4,
                 bus1.IFIDvalid, bus1.fsmState, bus1.stallCount, bus1.flushCount, bus1.stallTimeout);
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"},     bus1.instrMemAddr, m_pc);
        chk({tag, ".instr"},  bus1.IFIDinstr, m_instr);
        chk({tag, ".fields"}, {16'd0, bus1.IFIDopcode, bus1.IFIDRegrs, bus1.IFIDRegrt}, {16'd0, m_instr[31:16]});
        chk({tag, ".p4"},     bus1.IFIDpcPlus4, m_p4);
        chk({tag, ".valid"},  32'(bus1.IFIDvalid), 32'(m_v));
        chk({tag, ".state"},  32'(bus1.fsmState), 32'(m_st));
        chk({tag, ".stalls"}, 32'(bus1.stallCount), 32'(m_sc));
        chk({tag, ".flushes"},32'(bus1.flushCount), 32'(m_fc));
        chk({tag, ".timeout"},32'(bus1.stallTimeout), 32'(m_to));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        h, rh, f, b;
        logic [31:0] tgt;
        logic [31:0] e_pc, e_p4;
        logic        e_v;
        logic [1:0]  e_st;
        logic [15:0] e_sc, e_fc;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [31:0] e_instr;

        //            h  rh f  b  tgt           pc            p4            v  st  sc  fc
        tbl[0]  = '{0, 0, 0, 0, 32'h0,       32'h4,       32'h4,       1, 0, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 32'h0,       32'h8,       32'h8,       1, 0, 0, 0};
        tbl[2]  = '{1, 1, 1, 0, 32'h0,       32'h8,       32'h8,       1, 1, 1, 0}; // load-use
        tbl[3]  = '{0, 0, 0, 0, 32'h0,       32'hC,       32'hC,       1, 0, 1, 0};
        tbl[4]  = '{0, 0, 0, 0, 32'h0,       32'h10,      32'h10,      1, 0, 1, 0};
        tbl[5]  = '{0, 0, 0, 1, 32'h43,      32'h40,      32'h0,       0, 2, 1, 1}; // redirect
        tbl[6]  = '{0, 0, 0, 0, 32'h0,       32'h44,      32'h44,      1, 0, 1, 1};
        tbl[7]  = '{1, 0, 0, 1, 32'h100,     32'h44,      32'h48,      1, 1, 2, 1}; // branch ignored
        tbl[8]  = '{0, 0, 1, 0, 32'h0,       32'h48,      32'h0,       0, 0, 2, 2}; // flush
        tbl[9]  = '{0, 1, 1, 0, 32'h0,       32'h4C,      32'h0,       0, 0, 2, 2}; // hold beats flush
        tbl[10] = '{0, 1, 0, 1, 32'h202,     32'h200,     32'h0,       0, 2, 2, 2}; // branch, IF/ID held
        tbl[11] = '{0, 0, 0, 0, 32'h0,       32'h204,     32'h204,     1, 0, 2, 2};

        rst1 = 1; rst2 = 1;
        bus1.pcHOLD = 0; bus1.IFIDRegHOLD = 0; bus1.IFflush = 0; bus1.branchTaken = 0; bus1.branchTarget = 0;
        bus2.pcHOLD = 0; bus2.IFIDRegHOLD = 0; bus2.IFflush = 0; bus2.branchTaken = 0; bus2.branchTarget = 0;

        // Reset with every request asserted must still give the reset state.
        drive1(1, 1, 1, 1, 1, 32'h1234);
        chk("reset.pc",      bus1.instrMemAddr, 32'h0);
        chk("reset.instr",   bus1.IFIDinstr, 32'h0);
        chk("reset.p4",      bus1.IFIDpcPlus4, 32'h0);
        chk("reset.valid",   32'(bus1.IFIDvalid), 32'h0);
        chk("reset.state",   32'(bus1.fsmState), 32'h0);
        chk("reset.counts",  {bus1.stallCount, bus1.flushCount}, 32'h0);
        chk("reset.timeout", 32'(bus1.stallTimeout), 32'h0);

        for (int i = 0; i < 12; i++) begin
            drive1(0, tbl[i].h, tbl[i].rh, tbl[i].f, tbl[i].b, tbl[i].tgt);
            e_instr = tbl[i].e_v ? mem_word(tbl[i].e_p4 - 32'd4) : 32'h0;
            chk($sformatf("vec%0d.pc", i),     bus1.instrMemAddr, tbl[i].e_pc);
            chk($sformatf("vec%0d.instr", i),  bus1.IFIDinstr, e_instr);
            chk($sformatf("vec%0d.opcode", i), 32'(bus1.IFIDopcode), 32'(e_instr[31:26]));
            chk($sformatf("vec%0d.p4", i),     bus1.IFIDpcPlus4, tbl[i].e_p4);
            chk($sformatf("vec%0d.valid", i),  32'(bus1.IFIDvalid), 32'(tbl[i].e_v));
            chk($sformatf("vec%0d.state", i),  32'(bus1.fsmState), 32'(tbl[i].e_st));
            chk($sformatf("vec%0d.stalls", i), 32'(bus1.stallCount), 32'(tbl[i].e_sc));
            chk($sformatf("vec%0d.flushes", i),32'(bus1.flushCount), 32'(tbl[i].e_fc));
        end

        // Stall timeout: not after 7 holds, set after the 8th, sticky after release.
        drive1(1, 0, 0, 0, 0, 32'h0);
        for (int i = 1; i <= MAXS; i++) begin
            drive1(0, 1, 0, 0, 0, 32'h0);
            if (i == MAXS - 1) chk("timeout.before", 32'(bus1.stallTimeout), 32'h0);
        end
        chk("timeout.set",   32'(bus1.stallTimeout), 32'h1);
        chk("timeout.pc",    bus1.instrMemAddr, 32'h0);
        drive1(0, 0, 0, 0, 0, 32'h0);
        chk("timeout.stick", 32'(bus1.stallTimeout), 32'h1);
        chk("timeout.pc4",   bus1.instrMemAddr, 32'h4);

        // Reset mid-stall with a pending branch discards everything.
        drive1(0, 1, 0, 0, 1, 32'h800);
        drive1(1, 1, 0, 0, 1, 32'h800);
        chk("rststall.pc",      bus1.instrMemAddr, 32'h0);
        chk("rststall.valid",   32'(bus1.IFIDvalid), 32'h0);
        chk("rststall.state",   32'(bus1.fsmState), 32'h0);
        chk("rststall.timeout", 32'(bus1.stallTimeout), 32'h0);
        chk("rststall.stalls",  32'(bus1.stallCount), 32'h0);
        drive1(0, 0, 0, 0, 0, 32'h0);
        chk("rststall.fetch",   bus1.IFIDinstr, mem_word(32'h0));
        chk("rststall.p4",      bus1.IFIDpcPlus4, 32'h4);

        // PC wrap from RESET_PC = FFFFFFFC.
        @(posedge clk); #1;
        chk("wrap.resetpc", bus2.instrMemAddr, 32'hFFFF_FFFC);
        rst2 = 0;
        @(posedge clk); #1;
        $display("[TB] wrap: pc=%h instr=%h p4=%h v=%0b", bus2.instrMemAddr, bus2.IFIDinstr, bus2.IFIDpcPlus4, bus2.IFIDvalid);
        chk("wrap.pc",    bus2.instrMemAddr, 32'h0);
        chk("wrap.p4",    bus2.IFIDpcPlus4, 32'h0);
        chk("wrap.instr", bus2.IFIDinstr, mem_word(32'hFFFF_FFFC));
        chk("wrap.valid", 32'(bus2.IFIDvalid), 32'h1);

        // Randomized traffic against the model; some windows hold heavily.
        drive1(1, 0, 0, 0, 0, 32'h0);
        check_model("rnd.reset");
        for (int i = 0; i < 400; i++) begin
            logic r, h, rh, f, b;
            logic [31:0] t;
            int hp;
            hp = ((i / 40) % 2 == 1) ? 9 : 3;
            r  = ($urandom_range(0, 99) == 0);
            h  = ($urandom_range(0, 9) < hp);
            rh = ($urandom_range(0, 9) < 3);
            f  = ($urandom_range(0, 9) < 2);
            b  = ($urandom_range(0, 9) < 3);
            t  = $urandom;
            drive1(r, h, rh, f, b, t);
            check_model($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
